aes_dec_out_buffer: RTL and testbench
=====================================

AES_DEC_OUT_BUFFER -- requirements
Module: aes_dec_out_buffer

Interface
REQ-001 The parameter list SHALL be: DEPTH, 16, number of 128-bit entries and maximum outstanding credits (power of two, 4..64).
REQ-002 Port list:
  - clk  input  1  the only clock; all state changes on its rising edge.
  - rst  input  1  asynchronous, active-high reset.
  - issue  input  1  one-cycle pulse, in parallel with the AES_dec enable for each block launched into the core.
  - core_out  input  128  AES_dec OUT bus.
  - core_valid  input  1  AES_dec valid_out.
  - m_data  output  128  head-of-buffer plaintext.
  - m_valid  output  1  buffer non-empty.
  - m_ready  input  1  consumer accepts m_data.
  - issue_ok  output  1  upstream may launch another block this cycle.
  - count  output  log2(DEPTH)+1  entries stored.
  - overflow  output  1  sticky error flag.

Function
REQ-003 The block SHALL store core_out in a DEPTH-entry circular FIFO, using write pointer wp, read pointer rp and count.
REQ-004 Push: on a rising edge with core_valid=1, core_out SHALL be written at wp and wp SHALL advance by 1 mod DEPTH.
REQ-005 Pop: on a rising edge with m_valid=1 and m_ready=1, rp SHALL advance by 1 mod DEPTH.
REQ-006 Pointer wrap: a pointer SHALL go from DEPTH-1 to 0 with no lost or duplicated entry.
REQ-007 m_valid SHALL equal (count != 0).
REQ-008 m_data SHALL be the entry at rp when m_valid=1, and 128'h0 when empty.
REQ-009 m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-010 count SHALL update in the same edge as a push or pop:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on simultaneous push and pop.
REQ-011 Full with simultaneous push and pop: the push SHALL be accepted, the head SHALL be popped, and count SHALL stay DEPTH.
REQ-012 Full with push and no pop: the push SHALL be dropped, FIFO contents SHALL be unchanged, and overflow SHALL set.
REQ-013 Empty with simultaneous push and pop: no pop SHALL occur, because m_valid=0; the push SHALL complete, and m_valid SHALL rise the next cycle.
REQ-014 Latency: data pushed into an empty buffer SHALL appear on m_data with m_valid=1 exactly one cycle after the push edge.
REQ-015 Credit counter credits (0..DEPTH) SHALL track blocks issued but not yet popped:
  - +1 on an accepted issue;
  - -1 on pop;
  - unchanged when both occur in the same cycle.
REQ-016 issue_ok SHALL be combinational and equal (credits < DEPTH); a pop in the same cycle SHALL NOT raise it.
REQ-017 An issue with issue_ok=0 SHALL be ignored by the credit counter and SHALL set overflow.
REQ-018 Because credits cover in-flight and stored blocks, a core_valid push SHALL never meet a full FIFO while issue is honoured; REQ-012 covers misuse only.
REQ-019 A core_valid with credits=0 SHALL set overflow, since the push is unmatched, and the push SHALL still follow REQ-004/REQ-012.
REQ-020 overflow SHALL stay at 1 until rst.
REQ-021 Throughput: the buffer SHALL sustain one push and one pop per cycle indefinitely.

Reset
REQ-022 While rst=1, asynchronously:
  - wp, rp, count and credits SHALL be 0;
  - m_valid=0, m_data=0, issue_ok=1, overflow=0.
REQ-023 Reset mid-operation SHALL discard all stored and in-flight accounting.
REQ-024 Core outputs arriving in the first cycle after rst falls SHALL be treated as normal pushes, subject to REQ-019.
REQ-025 Storage array contents need not be cleared by reset.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
  - Single block: issue=1 one cycle; 11 cycles later, core_valid=1 with core_out=00112233445566778899AABBCCDDEEFF and m_ready=1 -> next cycle m_valid=1 with that value; the following cycle m_valid=0, count=0, credits=0.
  - Stream of 11 issues back-to-back with m_ready=0 -> issue_ok stays 1; after 11 pushes count=11; then m_ready=1 -> plaintexts appear in issue order, one per cycle, ending with cccccccccccccccccccccccccccccccc.
  - Credit limit: 16 issues with m_ready=0 -> issue_ok=0 after the 16th; a 17th issue sets overflow; one pop -> issue_ok=1 the next cycle.
  - Wrap-around: 40 blocks 0..39 pushed and popped, with m_ready toggling every cycle -> output order exact; pointers wrap twice.
  - Full FIFO with core_valid=1 and m_ready=1 -> push accepted and count stays 16; the same with m_ready=0 -> data dropped and overflow=1.
  - rst pulse with count=5 and credits=9 -> all outputs at reset values within the same cycle; overflow=0.

Source files
------------

// File: rtl/aes_dec_out_buffer.sv
// Output buffer for the AES decryption core: a DEPTH-entry plaintext FIFO plus
// a credit counter that throttles block launches so the FIFO cannot overrun.
module aes_dec_out_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue,
  input  logic [127:0]             core_out,
  input  logic                     core_valid,
  output logic [127:0]             m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     issue_ok,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d, cred_q, cred_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, push, iss_acc, cred_dec;

  assign full     = (count_q == CW'(DEPTH));
  assign m_valid  = (count_q != '0);
  assign pop      = m_valid && m_ready;
  // A full buffer still takes a push when the head leaves on the same edge.
  assign push     = core_valid && (!full || pop);
  assign issue_ok = (cred_q < CW'(DEPTH));
  assign iss_acc  = issue && issue_ok;
  // Unmatched pushes can leave data without credits; never wrap below zero.
  assign cred_dec = pop && (cred_q != '0);

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    cred_d  = cred_q;
    ovf_d   = ovf_q;
    if (push) wp_d = wp_q + AW'(1);
    if (pop)  rp_d = rp_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    unique case ({iss_acc, cred_dec})
      2'b10:   cred_d = cred_q + CW'(1);
      2'b01:   cred_d = cred_q - CW'(1);
      default: cred_d = cred_q;
    endcase
    if ((issue && !issue_ok) || (core_valid && !push) || (core_valid && cred_q == '0))
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      cred_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      cred_q  <= cred_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= core_out;
  end

  assign m_data   = m_valid ? mem_q[rp_q] : '0;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_aes_dec_out_buffer.sv
// Scoreboard bench for aes_dec_out_buffer: queue-based reference model at the
// clock edge, negedge monitor comparing every visible output.
module tb_aes_dec_out_buffer;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0, rst = 1'b0;
  logic          issue = 1'b0, core_valid = 1'b0, m_ready = 1'b0;
  logic [127:0]  core_out = '0;
  logic [127:0]  m_data;
  logic          m_valid, issue_ok, overflow;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  aes_dec_out_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .issue(issue), .core_out(core_out),
    .core_valid(core_valid), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .issue_ok(issue_ok), .count(count), .overflow(overflow)
  );

  int nvec = 0, nerr = 0;
  logic [127:0] mq[$];   // model FIFO contents
  logic [127:0] sbq[$];  // expected output stream
  int mcred = 0;
  bit movf = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, credits as an integer.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); sbq.delete(); mcred = 0; movf = 1'b0;
    end else begin
      bit p_pop, p_push, p_iacc;
      p_pop  = (mq.size() != 0) && m_ready;
      p_push = core_valid && ((mq.size() < DEPTH) || p_pop);
      p_iacc = issue && (mcred < DEPTH);
      if (issue && !p_iacc) movf = 1'b1;
      if (core_valid && mcred == 0) movf = 1'b1;
      if (core_valid && !p_push) movf = 1'b1;
      if (p_pop) void'(mq.pop_front());
      if (p_push) begin mq.push_back(core_out); sbq.push_back(core_out); end
      mcred = mcred + (p_iacc ? 1 : 0) - ((p_pop && mcred > 0) ? 1 : 0);
    end
  end

  // Monitor: sampled mid-cycle, the handshake seen here completes at the next edge.
  always @(negedge clk) begin
    if (rst || $time > 3) begin
      chk("m_valid", 128'(m_valid), 128'(mq.size() != 0));
      chk("count", 128'(count), 128'(mq.size()));
      chk("issue_ok", 128'(issue_ok), 128'(mcred < DEPTH));
      chk("overflow", 128'(overflow), 128'(movf));
      if (!m_valid) chk("m_data_empty", m_data, '0);
      else if (m_ready && !rst) begin
        if (sbq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL m_data_unexpected: got %h expected nothing", m_data);
        end else chk("m_data", m_data, sbq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; issue = 1'b0; core_valid = 1'b0; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin issue = 1'b1; tick(); end
    issue = 1'b0;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      core_valid = 1'b1; core_out = {$urandom(), $urandom(), $urandom(), $urandom()}; tick();
    end
    core_valid = 1'b0;
  endtask

  initial begin
    int next_blk, pushed, pend, cyc;
    logic [127:0] v;
    #2 rst = 1'b1;
    #1;
    chk("rst_m_valid", 128'(m_valid), 128'(0));
    chk("rst_m_data", m_data, '0);
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_issue_ok", 128'(issue_ok), 128'(1));
    chk("rst_overflow", 128'(overflow), 128'(0));
    do_reset();

    // Single block, 11-cycle core latency
    issue = 1'b1; tick(); issue = 1'b0;
    repeat (10) tick();
    core_valid = 1'b1; core_out = 128'h00112233445566778899AABBCCDDEEFF; m_ready = 1'b1;
    tick(); core_valid = 1'b0;
    chk("s1_valid", 128'(m_valid), 128'(1));
    chk("s1_data", m_data, 128'h00112233445566778899AABBCCDDEEFF);
    tick();
    chk("s1_empty", 128'(m_valid), 128'(0));
    chk("s1_count", 128'(count), 128'(0));
    chk("s1_issue_ok", 128'(issue_ok), 128'(1));
    m_ready = 1'b0;

    // Stream of 11, drained in order
    do_reset();
    for (int i = 0; i < 11; i++) begin
      issue = 1'b1; tick();
      chk("s2_issue_ok", 128'(issue_ok), 128'(1));
    end
    issue = 1'b0;
    for (int i = 0; i < 11; i++) begin
      core_valid = 1'b1; core_out = {32{4'(i + 2)}}; tick();
    end
    core_valid = 1'b0;
    chk("s2_count", 128'(count), 128'(11));
    m_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      v = {32{4'(i + 2)}};
      chk("s2_order", m_data, v);
      tick();
    end
    chk("s2_last_empty", 128'(m_valid), 128'(0));
    m_ready = 1'b0;

    // Credit limit
    do_reset();
    issue_n(16);
    chk("s3_issue_ok_lo", 128'(issue_ok), 128'(0));
    chk("s3_no_ovf", 128'(overflow), 128'(0));
    issue_n(1);
    chk("s3_ovf", 128'(overflow), 128'(1));
    push_n(1);
    m_ready = 1'b1;
    chk("s3_pop_cycle_lo", 128'(issue_ok), 128'(0));
    tick(); m_ready = 1'b0;
    chk("s3_issue_ok_hi", 128'(issue_ok), 128'(1));

    // Wrap-around: 40 indexed blocks, issue one cycle ahead of the push
    do_reset();
    next_blk = 0; pushed = 0; pend = 0; cyc = 0;
    while ((pushed < 40 || mq.size() != 0) && cyc < 1000) begin
      issue      = (next_blk < 40) && (mcred < DEPTH);
      core_valid = (pend > 0);
      core_out   = 128'(pushed);
      m_ready    = cyc[0];
      tick();
      if (issue) begin next_blk++; pend++; end
      if (core_valid) begin pend--; pushed++; end
      cyc++;
    end
    issue = 1'b0; core_valid = 1'b0; m_ready = 1'b0;
    if (cyc >= 1000) begin
      nvec++; nerr++;
      $display("FAIL s4_timeout: got %0d pushed expected 40", pushed);
    end
    chk("s4_drained", 128'(sbq.size()), 128'(0));
    chk("s4_no_ovf", 128'(overflow), 128'(0));

    // Full FIFO: push+pop accepted, push alone dropped
    do_reset();
    issue_n(16);
    push_n(16);
    chk("s5_full", 128'(count), 128'(16));
    core_valid = 1'b1; core_out = 128'hA5A5; m_ready = 1'b1; tick();
    chk("s5_pushpop_count", 128'(count), 128'(16));
    chk("s5_pushpop_ovf", 128'(overflow), 128'(0));
    core_out = 128'hDEAD; m_ready = 1'b0; tick(); core_valid = 1'b0;
    chk("s5_drop_count", 128'(count), 128'(16));
    chk("s5_drop_ovf", 128'(overflow), 128'(1));
    m_ready = 1'b1; repeat (16) tick(); m_ready = 1'b0;
    chk("s5_drain", 128'(count), 128'(0));

    // Asynchronous reset mid-operation
    do_reset();
    issue_n(9);
    push_n(5);
    chk("s6_pre_count", 128'(count), 128'(5));
    rst = 1'b1; #1;
    chk("s6_m_valid", 128'(m_valid), 128'(0));
    chk("s6_m_data", m_data, '0);
    chk("s6_count", 128'(count), 128'(0));
    chk("s6_issue_ok", 128'(issue_ok), 128'(1));
    chk("s6_overflow", 128'(overflow), 128'(0));
    tick(); rst = 1'b0;
    core_valid = 1'b1; core_out = 128'h1234; tick(); core_valid = 1'b0;
    chk("s6_post_count", 128'(count), 128'(1));
    chk("s6_post_ovf", 128'(overflow), 128'(1));

    // Random traffic, mostly well-behaved with occasional unmatched pushes
    do_reset();
    pend = 0;
    for (int i = 0; i < 400; i++) begin
      bit iacc, legal;
      issue      = ($urandom_range(0, 1) == 1);
      iacc       = issue && (mcred < DEPTH);
      legal      = (pend > 0) && ($urandom_range(0, 2) != 0);
      core_valid = legal || ($urandom_range(0, 49) == 0);
      core_out   = {$urandom(), $urandom(), $urandom(), $urandom()};
      m_ready    = ($urandom_range(0, 3) != 0);
      tick();
      if (iacc) pend++;
      if (core_valid && pend > 0) pend--;
    end
    issue = 1'b0; core_valid = 1'b0; m_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    m_ready = 1'b0;
    chk("rand_drained", 128'(count), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
